// File: rtl/stack_arbiter_pkg.sv
// Shared encodings for the stack arbiter: stack ops, stack status,
// requester IDs and arbiter FSM states, plus the empty/full guard rule.
package stack_arbiter_pkg;

  localparam logic [1:0] OP_NONE    = 2'd0;
  localparam logic [1:0] OP_PUSH    = 2'd1;
  localparam logic [1:0] OP_POP     = 2'd2;
  localparam logic [1:0] OP_REPLACE = 2'd3;

  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_EMPTY = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } arb_state_t;

  // An op that the stack cannot perform in its current state is answered
  // with an error instead of being issued.
  function automatic logic guard_reject(input logic [1:0] op, input logic [1:0] status);
    return (((op == OP_POP) || (op == OP_REPLACE)) && (status == ST_EMPTY)) ||
           ((op == OP_PUSH) && (status == ST_FULL));
  endfunction

endpackage

// File: rtl/stack_arbiter_rr_arbiter2.sv
// Two-way round-robin grant with a last-grant register and a lock mask.
// Latency: combinational grant; last-grant updates on the accepting edge.
// Backpressure: a masked or idle requester never receives a grant.
module rr_arbiter2
  import stack_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       accept,
  output logic [1:0] grant
);

  logic       last_grant;
  logic [1:0] eligible;

  assign eligible = req & ~mask;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    grant = eligible;
    if (eligible == 2'b11) begin
      grant = (last_grant == REQ_HOST) ? 2'b01 : 2'b10;
    end
  end

  // Remember who was served; reset favours the core on the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= REQ_HOST;
    end else if (accept && (grant != 2'b00)) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Arbitrates core/host stack ops onto one stack port; optional owner lock via STACK_ARB_LOCK_EN.
// Latency: response 2 cycles after handshake when issued, 1 cycle when guarded or NONE.
// Backpressure: one op outstanding; ready only in IDLE for the granted requester.
module stack_arbiter
  import stack_arbiter_pkg::*;
#(
  parameter int WIDTH = 66
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_lock,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_lock,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_tos,
  output logic [1:0]       rsp0_status,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_tos,
  output logic [1:0]       rsp1_status,
  output logic             rsp1_err,
  output logic [1:0]       stack_op,
  output logic [WIDTH-1:0] stack_data,
  input  logic [WIDTH-1:0] stack_tos,
  input  logic [1:0]       stack_status
);

  arb_state_t       state;
  logic             owner;
  logic [1:0]       grant;
  logic [1:0]       lock_mask;
  logic             in_idle;
  logic             hs;
  logic             sel;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_data;
  logic             reject;
  logic [WIDTH-1:0] tos_hold0, tos_hold1;
  logic [1:0]       status_hold0, status_hold1;

  assign in_idle = (state == S_IDLE) && !reset;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    ({req1_valid, req0_valid}),
    .mask   (lock_mask),
    .accept (in_idle),
    .grant  (grant)
  );

  assign req0_ready = in_idle && grant[0];
  assign req1_ready = in_idle && grant[1];
  assign hs         = req0_ready || req1_ready;
  assign sel        = grant[1];
  assign sel_op     = sel ? req1_op : req0_op;
  assign sel_data   = sel ? req1_data : req0_data;
  assign reject     = guard_reject(sel_op, stack_status);

`ifdef STACK_ARB_LOCK_EN
  logic lock_active;
  logic lock_owner;

  // The requester holding the lock masks out the other one.
  assign lock_mask = lock_active ? (lock_owner ? 2'b01 : 2'b10) : 2'b00;

  // Every accepted request, guarded or not, sets or releases ownership.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_active <= 1'b0;
      lock_owner  <= REQ_CORE;
    end else if (hs) begin
      lock_active <= sel ? req1_lock : req0_lock;
      lock_owner  <= sel;
    end
  end
`else
  // Lock inputs are part of the port list but have no effect here.
  logic unused_lock;
  assign unused_lock = req0_lock ^ req1_lock;
  assign lock_mask   = 2'b00;
`endif

  // The live stack view is forwarded during the response pulse, then held.
  assign rsp0_tos    = rsp0_valid ? stack_tos : tos_hold0;
  assign rsp1_tos    = rsp1_valid ? stack_tos : tos_hold1;
  assign rsp0_status = rsp0_valid ? stack_status : status_hold0;
  assign rsp1_status = rsp1_valid ? stack_status : status_hold1;

  // IDLE -> ISSUE -> RESP, or IDLE -> RESP for guarded/NONE ops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      owner        <= REQ_CORE;
      stack_op     <= OP_NONE;
      stack_data   <= '0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp0_err     <= 1'b0;
      rsp1_err     <= 1'b0;
      tos_hold0    <= '0;
      tos_hold1    <= '0;
      status_hold0 <= '0;
      status_hold1 <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hs) begin
            owner <= sel;
            if (reject || (sel_op == OP_NONE)) begin
              state      <= S_RESP;
              rsp0_valid <= !sel;
              rsp1_valid <= sel;
              if (sel) rsp1_err <= reject;
              else     rsp0_err <= reject;
            end else begin
              state      <= S_ISSUE;
              stack_op   <= sel_op;
              stack_data <= sel_data;
            end
          end
        end
        S_ISSUE: begin
          state      <= S_RESP;
          stack_op   <= OP_NONE;
          rsp0_valid <= !owner;
          rsp1_valid <= owner;
          if (owner) rsp1_err <= 1'b0;
          else       rsp0_err <= 1'b0;
        end
        S_RESP: begin
          state      <= S_IDLE;
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          if (owner) begin
            tos_hold1    <= stack_tos;
            status_hold1 <= stack_status;
          end else begin
            tos_hold0    <= stack_tos;
            status_hold0 <= stack_status;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: an 8-entry behavioural stack on the stack port,
// scenario tasks and a queue-based reference model of grants and responses.
module tb_stack_arbiter;
  import stack_arbiter_pkg::*;

  localparam int W = 66;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] data;
    logic         lock;
  } req_t;

  logic clk, reset;
  logic req0_valid, req0_lock, req0_ready, req1_valid, req1_lock, req1_ready;
  logic [1:0] req0_op, req1_op, rsp0_status, rsp1_status, stack_op, stack_status;
  logic [W-1:0] req0_data, req1_data, rsp0_tos, rsp1_tos, stack_data, stack_tos;
  logic rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;

  stack_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_data(req0_data), .req0_lock(req0_lock), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_data(req1_data), .req1_lock(req1_lock), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_tos(rsp0_tos), .rsp0_status(rsp0_status), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_tos(rsp1_tos), .rsp1_status(rsp1_status), .rsp1_err(rsp1_err),
    .stack_op(stack_op), .stack_data(stack_data), .stack_tos(stack_tos), .stack_status(stack_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 8-entry stack attached to the arbiter's stack port.
  logic [W-1:0] tb_mem [8];
  logic [3:0]   tb_cnt;
  logic [2:0]   tb_top;
  assign tb_top = 3'(tb_cnt - 4'd1);

  always @(posedge clk or posedge reset) begin
    if (reset) tb_cnt <= 4'd0;
    else begin
      case (stack_op)
        OP_PUSH:    if (tb_cnt < 4'd8) begin tb_mem[tb_cnt[2:0]] <= stack_data; tb_cnt <= tb_cnt + 4'd1; end
        OP_POP:     if (tb_cnt > 4'd0) tb_cnt <= tb_cnt - 4'd1;
        OP_REPLACE: if (tb_cnt > 4'd0) tb_mem[tb_top] <= stack_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    stack_tos    = '0;
    stack_status = ST_OK;
    if (tb_cnt > 4'd0) stack_tos = tb_mem[tb_top];
    if (tb_cnt == 4'd0) stack_status = ST_EMPTY;
    else if (tb_cnt == 4'd8) stack_status = ST_FULL;
  end

  // Reference model state.
  int n_cmp, n_fail;
  req_t q0[$], q1[$];
  logic [W-1:0] m_stk[$];
  int cyc, idle_at, rsp_cyc, iss_cyc;
  logic m_last, m_lock_on, m_lock_owner, rsp_owner, rsp_err_e, hs0, hs1, saw_pop;
  logic [1:0] iss_op, rsp_status_e;
  logic [W-1:0] iss_data, rsp_tos_e;
  int rsp_log[$];

  task automatic model_reset();
    m_stk.delete(); rsp_log.delete();
    cyc = 0; idle_at = 0; rsp_cyc = -1; iss_cyc = -1;
    m_last = 1'b1; m_lock_on = 1'b0; m_lock_owner = 1'b0;
    hs0 = 1'b0; hs1 = 1'b0; saw_pop = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic drive_inputs(input bit gaps);
    if (hs0) begin void'(q0.pop_front()); req0_valid = 1'b0; hs0 = 1'b0; end
    if (hs1) begin void'(q1.pop_front()); req1_valid = 1'b0; hs1 = 1'b0; end
    if (!req0_valid && q0.size() != 0 && (!gaps || $urandom_range(3) != 0)) begin
      req0_valid = 1'b1; req0_op = q0[0].op; req0_data = q0[0].data; req0_lock = q0[0].lock;
    end
    if (!req1_valid && q1.size() != 0 && (!gaps || $urandom_range(3) != 0)) begin
      req1_valid = 1'b1; req1_op = q1[0].op; req1_data = q1[0].data; req1_lock = q1[0].lock;
    end
  endtask

  // One sampled cycle: predict grants, stack port and responses from the
  // stack rules, compare, then advance the model on a handshake.
  task automatic model_cycle();
    logic [1:0] want, exp_r, exp_op, exp_v;
    req_t r;
    logic who, guard;
    int depth;
    exp_r = 2'b00;
    if (cyc >= idle_at) begin
      want = {req1_valid, req0_valid};
`ifdef STACK_ARB_LOCK_EN
      if (m_lock_on) want[!m_lock_owner] = 1'b0;
`endif
      if (want == 2'b11) exp_r[!m_last] = 1'b1;
      else exp_r = want;
    end
    n_cmp++;
    if ({req1_ready, req0_ready} !== exp_r) begin
      n_fail++; $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, {req1_ready, req0_ready}, exp_r);
    end
    exp_op = (cyc == iss_cyc) ? iss_op : OP_NONE;
    if (stack_op === OP_POP) saw_pop = 1'b1;
    n_cmp++;
    if (stack_op !== exp_op || (cyc == iss_cyc && stack_data !== iss_data)) begin
      n_fail++; $display("FAIL stack_port cyc=%0d got op=%0d data=%h exp op=%0d data=%h", cyc, stack_op, stack_data, exp_op, iss_data);
    end
    exp_v = 2'b00;
    if (cyc == rsp_cyc) exp_v[rsp_owner] = 1'b1;
    if (rsp0_valid === 1'b1) rsp_log.push_back(0);
    if (rsp1_valid === 1'b1) rsp_log.push_back(1);
    n_cmp++;
    if ({rsp1_valid, rsp0_valid} !== exp_v) begin
      n_fail++; $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, {rsp1_valid, rsp0_valid}, exp_v);
    end else if (cyc == rsp_cyc) begin
      n_cmp++;
      if (rsp_owner ? ({rsp1_tos, rsp1_status, rsp1_err} !== {rsp_tos_e, rsp_status_e, rsp_err_e})
                    : ({rsp0_tos, rsp0_status, rsp0_err} !== {rsp_tos_e, rsp_status_e, rsp_err_e})) begin
        n_fail++;
        $display("FAIL rsp_data cyc=%0d owner=%0d got tos=%h st=%0d err=%b exp tos=%h st=%0d err=%b", cyc, rsp_owner,
                 rsp_owner ? rsp1_tos : rsp0_tos, rsp_owner ? rsp1_status : rsp0_status, rsp_owner ? rsp1_err : rsp0_err,
                 rsp_tos_e, rsp_status_e, rsp_err_e);
      end
    end
    if (exp_r != 2'b00) begin
      who = exp_r[1];
      r = who ? q1[0] : q0[0];
      if (who) hs1 = 1'b1; else hs0 = 1'b1;
      depth = m_stk.size();
      guard = ((r.op == OP_POP || r.op == OP_REPLACE) && depth == 0) || (r.op == OP_PUSH && depth == 8);
      if (guard || r.op == OP_NONE) begin
        rsp_cyc = cyc + 1; idle_at = cyc + 2;
      end else begin
        case (r.op)
          OP_PUSH: m_stk.push_back(r.data);
          OP_POP:  void'(m_stk.pop_back());
          default: m_stk[m_stk.size() - 1] = r.data;
        endcase
        iss_cyc = cyc + 1; iss_op = r.op; iss_data = r.data;
        rsp_cyc = cyc + 2; idle_at = cyc + 3;
      end
      rsp_owner = who; rsp_err_e = guard;
      rsp_tos_e = (m_stk.size() != 0) ? m_stk[$] : '0;
      rsp_status_e = (m_stk.size() == 0) ? ST_EMPTY : (m_stk.size() == 8) ? ST_FULL : ST_OK;
      m_last = who;
      m_lock_on = r.lock; m_lock_owner = who;
    end
  endtask

  task automatic run_ops(input bit gaps);
    int budget;
    budget = 0;
    drive_inputs(gaps);
    while ((q0.size() != 0 || q1.size() != 0 || cyc < idle_at) && budget < 3000) begin
      @(negedge clk);
      model_cycle();
      @(posedge clk); #1;
      cyc++; budget++;
      drive_inputs(gaps);
    end
    n_cmp++;
    if (budget >= 3000) begin
      n_fail++; $display("FAIL run_timeout cycles=%0d limit=3000", budget);
      q0.delete(); q1.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 1'b1; req0_op = OP_PUSH; req0_data = '1; req0_lock = 1'b0;
    req1_valid = 1'b1; req1_op = OP_PUSH; req1_data = '1; req1_lock = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b exp=00", {req1_ready, req0_ready}); end
    n_cmp++;
    if (stack_op !== OP_NONE || stack_data !== '0) begin n_fail++; $display("FAIL reset_stack got op=%0d data=%h exp 0/0", stack_op, stack_data); end
    n_cmp++;
    if ({rsp1_valid, rsp0_valid, rsp1_err, rsp0_err} !== 4'b0) begin
      n_fail++; $display("FAIL reset_rsp got=%b exp=0000", {rsp1_valid, rsp0_valid, rsp1_err, rsp0_err});
    end
    n_cmp++;
    if (rsp0_tos !== '0 || rsp1_tos !== '0 || rsp0_status !== 2'd0 || rsp1_status !== 2'd0) begin
      n_fail++; $display("FAIL reset_tos got=%h/%h st=%0d/%0d exp 0", rsp0_tos, rsp1_tos, rsp0_status, rsp1_status);
    end
    do_reset();
  endtask

  task automatic test_single_push();
    do_reset();
    q0.push_back('{OP_PUSH, {2'b01, 64'd5}, 1'b0});
    run_ops(1'b0);
    n_cmp++;
    if (rsp_log.size() != 1 || rsp0_tos !== {2'b01, 64'd5}) begin
      n_fail++; $display("FAIL single_push got rsps=%0d tos=%h exp 1/%h", rsp_log.size(), rsp0_tos, {2'b01, 64'd5});
    end
  endtask

  task automatic test_tie();
    do_reset();
    q0.push_back('{OP_PUSH, {2'b01, 64'd1}, 1'b0});
    q1.push_back('{OP_PUSH, {2'b01, 64'd2}, 1'b0});
    run_ops(1'b0);
    n_cmp++;
    if (rsp_log.size() != 2 || rsp_log[0] != 0 || rsp_log[1] != 1 || stack_tos !== {2'b01, 64'd2}) begin
      n_fail++; $display("FAIL tie_order got n=%0d tos=%h exp core,host tos=%h", rsp_log.size(), stack_tos, {2'b01, 64'd2});
    end
  endtask

  task automatic test_guard_empty();
    do_reset();
    q1.push_back('{OP_POP, '0, 1'b0});
    run_ops(1'b0);
    n_cmp++;
    if (saw_pop || rsp_log.size() != 1 || rsp1_err !== 1'b1) begin
      n_fail++; $display("FAIL guard_empty got pop_seen=%b rsps=%0d err=%b exp 0/1/1", saw_pop, rsp_log.size(), rsp1_err);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 1; k <= 9; k++) q0.push_back('{OP_PUSH, {2'b01, 64'(k)}, 1'b0});
    run_ops(1'b0);
    n_cmp++;
    if (stack_tos !== {2'b01, 64'd8} || stack_status !== ST_FULL || rsp0_err !== 1'b1) begin
      n_fail++; $display("FAIL full_push got tos=%h st=%0d err=%b exp tos=%h st=%0d err=1", stack_tos, stack_status, rsp0_err, {2'b01, 64'd8}, ST_FULL);
    end
  endtask

  task automatic test_lock();
    do_reset();
    q0.push_back('{OP_PUSH, {2'b01, 64'd7}, 1'b1});
    q0.push_back('{OP_POP, '0, 1'b0});
    q1.push_back('{OP_PUSH, {2'b01, 64'd9}, 1'b0});
    run_ops(1'b0);
    n_cmp++;
`ifdef STACK_ARB_LOCK_EN
    if (rsp_log.size() != 3 || rsp_log[1] != 0 || rsp_log[2] != 1) begin
      n_fail++; $display("FAIL lock_order got n=%0d exp core,core,host", rsp_log.size());
    end
`else
    if (rsp_log.size() != 3 || rsp_log[1] != 1 || rsp_log[2] != 0) begin
      n_fail++; $display("FAIL lock_order got n=%0d exp core,host,core", rsp_log.size());
    end
`endif
  endtask

  task automatic test_reset_issue();
    bit got;
    do_reset();
    req0_valid = 1'b1; req0_op = OP_PUSH; req0_data = {2'b01, 64'd3}; req0_lock = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (req0_ready === 1'b1) got = 1'b1;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    n_cmp++;
    if (!got || stack_op !== OP_PUSH) begin n_fail++; $display("FAIL issue_reach got hs=%b op=%0d exp 1/%0d", got, stack_op, OP_PUSH); end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (stack_op !== OP_NONE) begin n_fail++; $display("FAIL reset_in_issue op got=%0d exp=0", stack_op); end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({rsp1_valid, rsp0_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_no_rsp got=%b exp=00", {rsp1_valid, rsp0_valid}); end
    end
    @(posedge clk); #1;
    q0.push_back('{OP_PUSH, {2'b01, 64'd4}, 1'b0});
    run_ops(1'b0);
    n_cmp++;
    if (rsp_log.size() != 1 || stack_tos !== {2'b01, 64'd4}) begin
      n_fail++; $display("FAIL after_reset got rsps=%0d tos=%h exp 1/%h", rsp_log.size(), stack_tos, {2'b01, 64'd4});
    end
  endtask

  task automatic test_random();
    req_t r;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      r.op = (i % 3 == 0) ? 2'($urandom_range(3)) : (($urandom_range(2) != 0) ? OP_PUSH : OP_POP);
      r.data = {2'($urandom_range(3)), $urandom, $urandom};
      r.lock = (i == 39) ? 1'b0 : 1'($urandom_range(1));
      q0.push_back(r);
      r.op = 2'($urandom_range(3));
      r.data = {2'($urandom_range(3)), $urandom, $urandom};
      r.lock = (i == 39) ? 1'b0 : 1'($urandom_range(1));
      q1.push_back(r);
    end
    run_ops(1'b1);
    n_cmp++;
    if (rsp_log.size() != 80) begin n_fail++; $display("FAIL random_count got=%0d exp=80", rsp_log.size()); end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b1;
    req0_valid = 1'b0; req0_op = OP_NONE; req0_data = '0; req0_lock = 1'b0;
    req1_valid = 1'b0; req1_op = OP_NONE; req1_data = '0; req1_lock = 1'b0;
    model_reset();
    test_reset();
    test_single_push();
    test_tie();
    test_guard_empty();
    test_full();
    test_lock();
    test_reset_issue();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 Parameter: WIDTH, default 66, stack entry width ({type[1:0], value[63:0]}).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 reqN_valid  input  1  (N=0 core, N=1 host) requester N has a stack op pending.
REQ-005 reqN_op  input  2  requested op: `NONE/`PUSH/`POP/`REPLACE per stack.vh.
REQ-006 reqN_data  input  WIDTH  push/replace data.
REQ-007 reqN_lock  input  1  hold ownership after this op; always present, ignored unless STACK_ARB_LOCK_EN.
REQ-008 reqN_ready  output  1  request N accepted this cycle (valid && ready = handshake).
REQ-009 rspN_valid  output  1  one-cycle response pulse for requester N.
REQ-010 rspN_tos  output  WIDTH  stack top-of-stack after the op.
REQ-011 rspN_status  output  2  stack status after the op.
REQ-012 rspN_err  output  1  op rejected by guard, not issued.
REQ-013 stack_op  output  2  op to stack module.
REQ-014 stack_data  output  WIDTH  data to stack module.
REQ-015 stack_tos  input  WIDTH  stack top-of-stack.
REQ-016 stack_status  input  2  stack status (`EMPTY, `FULL, ...).

Function
REQ-017 FSM states IDLE, ISSUE, RESP; one op outstanding at a time.
REQ-018 IDLE: reqN_ready asserted combinationally only for the granted requester with reqN_valid=1; at most one ready high.
REQ-019 Handshake in IDLE latches op, data, lock, owner; next state ISSUE, or RESP directly if guarded.
REQ-020 Guard: POP/REPLACE while stack_status==`EMPTY, or PUSH while `FULL -> op not issued, RESP with rspN_err=1.
REQ-021 reqN_op==`NONE accepted, not issued to stack, RESP with err=0 (status query).
REQ-022 ISSUE: stack_op/stack_data = latched values for exactly one cycle; next state RESP.
REQ-023 Outside ISSUE, stack_op SHALL be `NONE.
REQ-024 RESP: rspN_valid=1 for owner only, rspN_tos=stack_tos, rspN_status=stack_status, err as latched; next state IDLE.
REQ-025 Latency: handshake cycle T -> response in cycle T+2 (issued) or T+1 (guarded/NONE); max throughput 1 op / 3 cycles.
REQ-026 Arbitration: round-robin; both valid in IDLE -> grant the requester not granted last; single valid -> that requester.
REQ-027 rsp outputs other than rspN_valid hold last values when rspN_valid=0; the bench checks them only when valid.
REQ-028 Requester SHALL hold reqN_valid/op/data stable until ready; the arbiter does not buffer unaccepted requests.

Reset
REQ-029 Reset SHALL force: state IDLE, stack_op `NONE, stack_data 0, all ready/rsp_valid/rsp_err 0, rsp_tos/status 0, last-grant = 1 (core wins first tie), lock clear.
REQ-030 Reset in ISSUE or RESP SHALL drop the in-flight op with no response; the stack is reset by the same signal.

Configuration
REQ-031 Macro STACK_ARB_LOCK_EN defined: an accepted request with lock=1 makes the owner exclusive; the other requester gets no ready until the owner's accepted request has lock=0; guarded requests honour lock too.
REQ-032 STACK_ARB_LOCK_EN undefined: reqN_lock ignored, pure round-robin per REQ-026; no lock register synthesized.

Structure
REQ-033 Op and status encodings SHALL come from shared stack.vh; FSM state encodings and requester IDs SHALL live in shared header stack_arb.vh.
REQ-034 One sub-module rr_arbiter2 (2-way round-robin grant, last-grant register, lock mask input); everything else in stack_arbiter.

Verification
REQ-035 Core PUSH {i32, 5} on empty stack -> stack_op=`PUSH at T+1, rsp0_valid at T+2 with tos={i32,5}, err=0.
REQ-036 Both valid in IDLE after reset, core PUSH 1, host PUSH 2 -> core granted first, host next; final tos={i32,2}, two responses in order.
REQ-037 Host POP on empty stack -> rsp1_valid at T+1, rsp1_err=1, stack_op never `POP.
REQ-038 LOCK_EN: core PUSH 7 lock=1, host valid throughout, core POP lock=0 -> host not ready until core's POP accepted; without macro host granted between them.
REQ-039 Reset asserted during ISSUE -> stack_op=`NONE immediately, no rsp pulse, next request served normally.
REQ-040 Push to `FULL stack (8 entries) -> rsp err=1, stack_op stays `NONE, tos unchanged.
